// File: rtl/ahfp_addsub_pipe.sv
// ahfp_addsub_pipe -- three-stage floating-point adder/subtractor.
// Format {sign, exponent, fraction}, hidden bit implied, subnormals flushed.
// Optional macro AHFP_ROUND_NEAREST_EN selects round-to-nearest-even in the
// last stage; without it the result is truncated (round toward zero).
module ahfp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_en,
  input  logic         start,
  input  logic         n,
  input  logic [W-1:0] dataa,
  input  logic [W-1:0] datab,
  output logic [W-1:0] result,
  output logic         done
);

  // Extended mantissa: hidden bit, fraction, guard, round, sticky.
  localparam int MW   = MAN_W + 4;
  // Signed exponent working width, room for carry and normalise underflow.
  localparam int EW   = EXP_W + 2;
  localparam int LZ_W = $clog2(MW + 1);

  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW-1:0] E_ONE    = {{(EW-1){1'b0}}, 1'b1};
  localparam logic signed [EW-1:0] E_ZERO   = '0;
  localparam logic signed [EW-1:0] E_MAX    = {2'b00, EXP_ONES};

  // Right-align the smaller mantissa; shifted-out bits fold into sticky.
  // Shifts that push the hidden bit at or past the sticky slot leave only sticky.
  function automatic logic [MW-1:0] align(input logic [MW-1:0] m,
                                          input logic [EXP_W-1:0] sh);
    logic [2*MW-1:0] wide;
    wide = {m, {MW{1'b0}}} >> sh;
    if (int'(sh) >= MW - 1)
      align = {{(MW-1){1'b0}}, |m};
    else
      align = {wide[2*MW-1:MW+1], wide[MW] | (|wide[MW-1:0])};
  endfunction

  // Leading-zero count of the un-carried sum; MW when the sum is zero.
  function automatic logic [LZ_W-1:0] lzc(input logic [MW-1:0] x);
    lzc = LZ_W'(MW);
    for (int i = 0; i < MW; i++)
      if (x[i]) lzc = LZ_W'(MW - 1 - i);
  endfunction

  // Round the normalised mantissa to MAN_W+1 bits; the top bit of the
  // return value flags a carry-out that needs renormalising.
  function automatic logic [MAN_W+1:0] round_mant(input logic [MW-1:0] nm);
    logic inc;
`ifdef AHFP_ROUND_NEAREST_EN
    inc = nm[2] & (nm[1] | nm[0] | nm[3]);
`else
    inc = 1'b0;
`endif
    round_mant = {1'b0, nm[MW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
  endfunction

  logic               sa, sb, a_zero, b_zero, a_max, b_max;
  logic               a_nan, b_nan, a_inf, b_inf, a_big, sp_s1;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic [MW-1:0]      ma, mb;
  logic [W-1:0]       spv_s1;

  // S1 combinational: unpack, flush subnormals, effective sign, specials.
  always_comb begin
    sa     = dataa[W-1];
    sb     = datab[W-1] ^ n;
    ea     = dataa[W-2:MAN_W];
    eb     = datab[W-2:MAN_W];
    fa     = dataa[MAN_W-1:0];
    fb     = datab[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_max  = (ea == EXP_ONES);
    b_max  = (eb == EXP_ONES);
    a_nan  = a_max & (|fa);
    b_nan  = b_max & (|fb);
    a_inf  = a_max & ~(|fa);
    b_inf  = b_max & ~(|fb);
    ma     = a_zero ? '0 : {1'b1, fa, 3'b000};
    mb     = b_zero ? '0 : {1'b1, fb, 3'b000};
    a_big  = ({ea, ma} >= {eb, mb});
    sp_s1  = a_nan | b_nan | a_inf | b_inf;
    spv_s1 = QNAN;
    if (a_nan | b_nan)
      spv_s1 = QNAN;
    else if (a_inf & b_inf)
      spv_s1 = (sa != sb) ? QNAN : {sa, EXP_ONES, {MAN_W{1'b0}}};
    else if (a_inf)
      spv_s1 = {sa, EXP_ONES, {MAN_W{1'b0}}};
    else if (b_inf)
      spv_s1 = {sb, EXP_ONES, {MAN_W{1'b0}}};
  end

  // ---- S1 / S2 boundary ----
  logic               vld_p0, sign_p0, same_p0, sp_p0;
  logic [EXP_W-1:0]   exp_p0;
  logic [MW-1:0]      mbig_p0, msml_p0;
  logic [W-1:0]       spv_p0;

  // S1 valid: a start is only accepted on an enabled, non-reset edge.
  always_ff @(posedge clk) begin
    if (reset)       vld_p0 <= 1'b0;
    else if (clk_en) vld_p0 <= start;
  end

  // S1 data: larger-magnitude operand first, smaller one aligned to it.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      sign_p0 <= a_big ? sa : sb;
      same_p0 <= (sa == sb);
      exp_p0  <= a_big ? ea : eb;
      mbig_p0 <= a_big ? ma : mb;
      msml_p0 <= align(a_big ? mb : ma, a_big ? (ea - eb) : (eb - ea));
      sp_p0   <= sp_s1;
      spv_p0  <= spv_s1;
    end
  end

  logic [MW:0] sum_s2;

  // S2 combinational: magnitude add or subtract; big >= small so no sign flip.
  always_comb begin
    if (same_p0) sum_s2 = {1'b0, mbig_p0} + {1'b0, msml_p0};
    else         sum_s2 = {1'b0, mbig_p0} - {1'b0, msml_p0};
  end

  // ---- S2 / S3 boundary ----
  logic               vld_p1, sign_p1, same_p1, sp_p1;
  logic [EXP_W-1:0]   exp_p1;
  logic [MW:0]        sum_p1;
  logic [W-1:0]       spv_p1;

  // S2 valid.
  always_ff @(posedge clk) begin
    if (reset)       vld_p1 <= 1'b0;
    else if (clk_en) vld_p1 <= vld_p0;
  end

  // S2 data.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      sum_p1  <= sum_s2;
      exp_p1  <= exp_p0;
      sign_p1 <= sign_p0;
      same_p1 <= same_p0;
      sp_p1   <= sp_p0;
      spv_p1  <= spv_p0;
    end
  end

  logic [LZ_W-1:0]      lz;
  logic [MW-1:0]        nm;
  logic [MAN_W+1:0]     mr;
  logic [MAN_W-1:0]     frac_s3;
  logic signed [EW-1:0] exp_ext, lz_ext, e_norm, e_fin;
  logic [W-1:0]         res_s3;

  // S3 combinational: normalise, round, then pack with zero/overflow/underflow.
  always_comb begin
    lz      = lzc(sum_p1[MW-1:0]);
    exp_ext = $signed({2'b00, exp_p1});
    lz_ext  = $signed({{(EW-LZ_W){1'b0}}, lz});
    if (sum_p1[MW]) begin
      nm     = {sum_p1[MW:2], sum_p1[1] | sum_p1[0]};
      e_norm = exp_ext + E_ONE;
    end else begin
      nm     = sum_p1[MW-1:0] << lz;
      e_norm = exp_ext - lz_ext;
    end
    mr      = round_mant(nm);
    frac_s3 = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
    e_fin   = mr[MAN_W+1] ? e_norm + E_ONE : e_norm;
    if (sp_p1)
      res_s3 = spv_p1;
    else if (sum_p1 == '0)
      res_s3 = {same_p1 & sign_p1, {(W-1){1'b0}}};
    else if (e_fin >= E_MAX)
      res_s3 = {sign_p1, EXP_ONES, {MAN_W{1'b0}}};
    else if (e_fin <= E_ZERO)
      res_s3 = {sign_p1, {(W-1){1'b0}}};
    else
      res_s3 = {sign_p1, e_fin[EXP_W-1:0], frac_s3};
  end

  // ---- S3 output register ----
  // done pulses once per completed operation; result holds until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      done   <= 1'b0;
      result <= '0;
    end else if (clk_en) begin
      done <= vld_p1;
      if (vld_p1) result <= res_s3;
    end
  end

endmodule

// File: tb/tb_ahfp_addsub_pipe.sv
// Bench for ahfp_addsub_pipe (default EXP_W=8, MAN_W=23): directed table,
// stall/reset sequences and randomized traffic against an exact-arithmetic model.
module tb_ahfp_addsub_pipe;

  logic        clk = 1'b0;
  logic        reset, clk_en, start, n;
  logic [31:0] dataa, datab, result;
  logic        done;

  int errors = 0;
  int checks = 0;

  ahfp_addsub_pipe dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n),
    .dataa(dataa), .datab(datab), .result(result), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Exact value of a +/- b, then rounded once to single precision.
  function automatic logic [31:0] model_addsub(input logic [31:0] a, input logic [31:0] b,
                                               input logic nn);
    logic         sa, sb, rs;
    int           ea, eb, emin, p, e;
    logic [22:0]  fa, fb;
    logic [319:0] ma, mb, s, keep, rem, half;
    sa = a[31]; sb = b[31] ^ nn;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = a[22:0]; fb = b[22:0];
    if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) return 32'h7FC00000;
    if (ea == 255 && eb == 255) return (sa != sb) ? 32'h7FC00000 : {sa, 8'hFF, 23'd0};
    if (ea == 255) return {sa, 8'hFF, 23'd0};
    if (eb == 255) return {sb, 8'hFF, 23'd0};
    ma = (ea == 0) ? '0 : 320'({1'b1, fa});
    mb = (eb == 0) ? '0 : 320'({1'b1, fb});
    if (ma == 0 && mb == 0) return {sa & sb, 31'd0};
    if (ma == 0)      emin = eb;
    else if (mb == 0) emin = ea;
    else              emin = (ea < eb) ? ea : eb;
    if (ma != 0) ma = ma << (ea - emin);
    if (mb != 0) mb = mb << (eb - emin);
    if (sa == sb)      begin s = ma + mb; rs = sa; end
    else if (ma >= mb) begin s = ma - mb; rs = sa; end
    else               begin s = mb - ma; rs = sb; end
    if (s == 0) return 32'h00000000;
    p = 0;
    for (int i = 0; i < 320; i++) if (s[i]) p = i;
    e = emin + p - 23;
    if (p > 23) begin
      keep = s >> (p - 23);
      rem  = s - (keep << (p - 23));
      half = 320'd1 << (p - 24);
`ifdef AHFP_ROUND_NEAREST_EN
      if (rem > half || (rem == half && keep[0])) keep = keep + 1;
      if (keep[24]) begin keep = keep >> 1; e = e + 1; end
`else
      if (rem > half) keep = keep;
`endif
    end else begin
      keep = s << (23 - p);
    end
    if (e >= 255) return {rs, 8'hFF, 23'd0};
    if (e <= 0)   return {rs, 31'd0};
    return {rs, e[7:0], keep[22:0]};
  endfunction

  function automatic logic [31:0] rand_special();
    case ($urandom_range(0, 7))
      0:       return 32'h00000000;
      1:       return 32'h80000000;
      2:       return 32'h7F800000;
      3:       return 32'hFF800000;
      4:       return 32'h7FC00000;
      5:       return {$urandom_range(0, 1) == 1, 8'h00, 23'($urandom)};
      6:       return 32'h7F7FFFFF;
      default: return 32'h00800000;
    endcase
  endfunction

  function automatic logic [31:0] rand_normal();
    return {$urandom_range(0, 1) == 1, 8'($urandom_range(1, 254)), 23'($urandom)};
  endfunction

  function automatic logic [31:0] rand_near(input logic [31:0] a);
    int          e;
    logic [22:0] f;
    e = int'(a[30:23]) + int'($urandom_range(0, 8)) - 4;
    if (e < 1) e = 1;
    if (e > 254) e = 254;
    f = ($urandom_range(0, 1) == 1) ? (a[22:0] ^ 23'($urandom_range(0, 15))) : 23'($urandom);
    return {$urandom_range(0, 1) == 1, e[7:0], f};
  endfunction

  // Called #1 after a rising edge; returns result, edges to done, pulse/hold flag.
  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic nn,
                         output logic [31:0] got, output int lat, output logic pulse_ok);
    dataa = a; datab = b; n = nn; start = 1'b1; clk_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    got = result;
    @(posedge clk); #1;
    pulse_ok = !done && (result == got);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        n;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [16];
  logic [31:0] got, a, b;
  logic        nn, en, st, pok;
  int          lat;
  logic [31:0] exp_q [$];
  int          edge_q [$];
  logic [31:0] res_q [$];
  logic        en_s [10];
  logic        st_s [10];
  int          op_s [10];
  int          stall_op [4];
  int          seen;

  initial begin
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000};
    vecs[1]  = '{32'h40400000, 32'h40A00000, 1'b1, 32'hC0000000};
    vecs[2]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000};
`ifdef AHFP_ROUND_NEAREST_EN
    vecs[3]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001};
    vecs[4]  = '{32'h4C800000, 32'h3F800000, 1'b1, 32'h4C800000};
`else
    vecs[3]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000};
    vecs[4]  = '{32'h4C800000, 32'h3F800000, 1'b1, 32'h4C7FFFFF};
`endif
    vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000};
    vecs[6]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000};
    vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000};
    vecs[8]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000};
    vecs[9]  = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000};
    vecs[10] = '{32'h80400000, 32'h80000000, 1'b0, 32'h80000000};
    vecs[11] = '{32'h3F800000, 32'h00000001, 1'b1, 32'h3F800000};
    vecs[12] = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000};
    vecs[13] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000};
    vecs[14] = '{32'hFF800000, 32'hFF800000, 1'b1, 32'h7FC00000};
    vecs[15] = '{32'h00800000, 32'h00C00000, 1'b1, 32'h80000000};

    // Reset with clk_en low and start high: must still clear and ignore start.
    reset = 1'b1; clk_en = 1'b0; start = 1'b1; n = 1'b0;
    dataa = 32'h3F800000; datab = 32'h3F800000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b0; start = 1'b0; clk_en = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      run_one(vecs[i].a, vecs[i].b, vecs[i].n, got, lat, pok);
      check($sformatf("vec%0d_result", i), got, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d_pulse_hold", i), {31'd0, pok}, 32'd1);
    end

    // Back-to-back starts with a two-cycle stall while a done is high.
    en_s = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    st_s = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    op_s = '{0, 1, 2, 3, 3, 3, 3, 3, 3, 3};
    stall_op = '{0, 1, 12, 5};
    for (int i = 0; i < 10; i++) begin
      clk_en = en_s[i]; start = st_s[i];
      dataa = vecs[stall_op[op_s[i]]].a;
      datab = vecs[stall_op[op_s[i]]].b;
      n     = vecs[stall_op[op_s[i]]].n;
      @(posedge clk); #1;
      if (en_s[i] && done) begin
        edge_q.push_back(i);
        res_q.push_back(result);
      end
      if (!en_s[i]) begin
        check("stall_freeze_done", {31'd0, done}, 32'd1);
        check("stall_freeze_result", result, vecs[0].exp);
      end
    end
    start = 1'b0; clk_en = 1'b1;
    check("stall_done_count", 32'(edge_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (edge_q.size() > 0) begin
        check($sformatf("stall_edge%0d", k), 32'(edge_q.pop_front()),
              (k == 0) ? 32'd2 : 32'(k + 4));
        check($sformatf("stall_result%0d", k), res_q.pop_front(), vecs[stall_op[k]].exp);
      end
    end

    // Reset one cycle after a start, with another start during the reset edge.
    dataa = 32'h40400000; datab = 32'h3F800000; n = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    dataa = 32'h40A00000; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    check("rst_flush_no_done", 32'(seen), 32'd0);
    check("rst_flush_result", result, 32'd0);
    run_one(32'h40400000, 32'h3F800000, 1'b0, got, lat, pok);
    check("post_reset_result", got, 32'h40800000);
    check("post_reset_latency", 32'(lat), 32'd3);

    // Randomized traffic with random stalls, in-order scoreboard.
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 4) != 0);
      st = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       a = rand_special();
        1:       a = {$urandom_range(0, 1) == 1, 8'($urandom_range(1, 4)), 23'($urandom)};
        default: a = rand_normal();
      endcase
      case ($urandom_range(0, 9))
        0:             b = rand_special();
        1:             b = $urandom;
        2, 3, 4, 5, 6: b = rand_near(a);
        default:       b = rand_normal();
      endcase
      nn = ($urandom_range(0, 1) == 1);
      clk_en = en; start = st; dataa = a; datab = b; n = nn;
      @(posedge clk); #1;
      if (en && done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rand_spurious_done: got done=1 expected no pending op");
        end else begin
          check("rand_result", result, exp_q.pop_front());
        end
      end
      if (en && st) exp_q.push_back(model_addsub(a, b, nn));
    end
    clk_en = 1'b1; start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL drain_spurious_done: got done=1 expected no pending op");
        end else begin
          check("drain_result", result, exp_q.pop_front());
        end
      end
    end
    check("rand_pending_left", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
